// File: rtl/rd_sched_pkg.sv
// Shared types and helpers for the read-return drain scheduler.
package rd_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } sched_state_e;

   localparam int ONEHOT_MAX = 64;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [ONEHOT_MAX-1:0] onehot_of(input int unsigned idx);
      return ONEHOT_MAX'(1) << idx;
   endfunction

endpackage

// File: rtl/rd_sched_rr_pick.sv
// Round-robin picker: first requester after ptr, scanning upward modulo NUM_SRC.
module rd_sched_rr_pick #(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               any,
   output logic [ID_W-1:0]    win
);

   logic [ID_W-1:0] idx;

   // Scan from the far end so the last hit written is the nearest to ptr+1.
   always_comb begin
      any = 1'b0;
      win = '0;
      idx = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         idx = ID_W'((int'(ptr) + k) % NUM_SRC);
         if (req[idx]) begin
            any = 1'b1;
            win = idx;
         end
      end
   end

endmodule

// File: rtl/rd_fifo_drain_sched.sv
// Round-robin burst drain of NUM_SRC read FIFOs onto one registered valid/ready channel.
//   state | meaning
//   IDLE  | no pops; arbitrate among non-empty FIFOs once the post-reset guard clears
//   BURST | pop the granted FIFO until a last beat or MAX_BEATS, stalling when it is empty
module rd_fifo_drain_sched
   import rd_sched_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 16,
   parameter int ID_W      = id_width(NUM_SRC)
) (
   input  logic                      rd_clk,
   input  logic                      rd_rst,
   input  logic [NUM_SRC-1:0]        src_empty,
   input  logic [NUM_SRC*DATA_W-1:0] src_rd_data,
   input  logic [NUM_SRC-1:0]        src_rd_last,
   output logic [NUM_SRC-1:0]        src_rd_en,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DATA_W-1:0]         m_data,
   output logic                      m_last,
   output logic [ID_W-1:0]           m_src_id,
   output logic                      err_overrun
);

   localparam int CNT_W = $clog2(MAX_BEATS) + 1;

   sched_state_e      state_q, state_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic              err_d;
   logic              guard_q;

   logic [DATA_W-1:0] data_arr [NUM_SRC];
   logic [DATA_W-1:0] cur_data;
   logic              cur_empty;
   logic              cur_last;
   logic              pop;
   logic              pick_any;
   logic [ID_W-1:0]   pick_win;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_split
      assign data_arr[i] = src_rd_data[i*DATA_W +: DATA_W];
   end

   assign cur_data  = data_arr[grant_q];
   assign cur_empty = src_empty[grant_q];
   assign cur_last  = src_rd_last[grant_q];

   assign pop       = (state_q == BURST) && !cur_empty && (!m_valid || m_ready);
   assign src_rd_en = pop ? NUM_SRC'(onehot_of({{(32-ID_W){1'b0}}, grant_q})) : '0;

   rd_sched_rr_pick #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_pick (
      .req (~src_empty),
      .ptr (rr_ptr_q),
      .any (pick_any),
      .win (pick_win)
   );

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      err_d      = err_overrun;
      case (state_q)
         IDLE: begin
            if (!guard_q && pick_any) begin
               grant_d    = pick_win;
               beat_cnt_d = '0;
               state_d    = BURST;
            end
         end
         BURST: begin
            if (pop) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if (cur_last) begin
                  state_d  = IDLE;
                  rr_ptr_d = grant_q;
               end else if (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) begin
                  // Forced release: the beat goes out without last and the error sticks.
                  state_d  = IDLE;
                  rr_ptr_d = grant_q;
                  err_d    = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= ID_W'(NUM_SRC - 1);
         beat_cnt_q  <= '0;
         err_overrun <= 1'b0;
         guard_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         beat_cnt_q  <= beat_cnt_d;
         err_overrun <= err_d;
         guard_q     <= 1'b0;
      end
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_last   <= 1'b0;
         m_src_id <= '0;
      end else if (pop) begin
         m_valid  <= 1'b1;
         m_data   <= cur_data;
         m_last   <= cur_last;
         m_src_id <= grant_q;
      end else if (m_valid && m_ready) begin
         m_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rd_fifo_drain_sched.sv
// Scoreboard bench for rd_fifo_drain_sched with per-source FIFO models.
module tb_rd_fifo_drain_sched;

   localparam int NUM_SRC   = 4;
   localparam int DATA_W    = 32;
   localparam int MAX_BEATS = 16;
   localparam int ID_W      = 2;

   logic                      rd_clk = 1'b0;
   logic                      rd_rst;
   logic [NUM_SRC-1:0]        src_empty;
   logic [NUM_SRC*DATA_W-1:0] src_rd_data;
   logic [NUM_SRC-1:0]        src_rd_last;
   logic [NUM_SRC-1:0]        src_rd_en;
   logic                      m_valid;
   logic                      m_ready;
   logic [DATA_W-1:0]         m_data;
   logic                      m_last;
   logic [ID_W-1:0]           m_src_id;
   logic                      err_overrun;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_t;

   beat_t              exp_q [$];
   logic [DATA_W:0]    fq [NUM_SRC][$];
   logic [NUM_SRC-1:0] en_snap;
   int                 n_checks = 0;
   int                 n_pass   = 0;

   rd_fifo_drain_sched #(
      .NUM_SRC   (NUM_SRC),
      .DATA_W    (DATA_W),
      .MAX_BEATS (MAX_BEATS),
      .ID_W      (ID_W)
   ) dut (
      .rd_clk      (rd_clk),
      .rd_rst      (rd_rst),
      .src_empty   (src_empty),
      .src_rd_data (src_rd_data),
      .src_rd_last (src_rd_last),
      .src_rd_en   (src_rd_en),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last),
      .m_src_id    (m_src_id),
      .err_overrun (err_overrun)
   );

   always #5 rd_clk = ~rd_clk;

   task automatic refresh();
      for (int i = 0; i < NUM_SRC; i++) begin
         src_empty[i] = (fq[i].size() == 0);
         src_rd_data[i*DATA_W +: DATA_W] = (fq[i].size() > 0) ? fq[i][0][DATA_W-1:0] : '0;
         src_rd_last[i] = (fq[i].size() > 0) ? fq[i][0][DATA_W] : 1'b0;
      end
   endtask

   // FIFO model: pops taken from the strobe seen before the edge, applied just after it.
   always begin
      @(negedge rd_clk);
      en_snap = src_rd_en;
      @(posedge rd_clk);
      #1;
      for (int i = 0; i < NUM_SRC; i++)
         if (en_snap[i] && fq[i].size() > 0) void'(fq[i].pop_front());
      refresh();
   end

   always @(negedge rd_clk) begin
      if (!rd_rst) begin
         n_checks++;
         if ($countones(src_rd_en) > 1 || (src_rd_en & src_empty) != '0)
            $display("FAIL rd_en_legal: src_rd_en=%b src_empty=%b", src_rd_en, src_empty);
         else
            n_pass++;
         if (m_valid && m_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_beat: id=%0d data=%h last=%b", m_src_id, m_data, m_last);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               if ({m_src_id, m_data, m_last} !== {e.id, e.data, e.last})
                  $display("FAIL beat: got id=%0d data=%h last=%b, want id=%0d data=%h last=%b",
                           m_src_id, m_data, m_last, e.id, e.data, e.last);
               else
                  n_pass++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge rd_clk);
      #2;
   endtask

   task automatic clear_all();
      for (int i = 0; i < NUM_SRC; i++) fq[i].delete();
      exp_q.delete();
      refresh();
   endtask

   task automatic push_exp(input int src, input int n, input logic [DATA_W-1:0] base,
                           input int first, input bit last_on_final);
      beat_t b;
      for (int j = first; j < first + n; j++) begin
         b.id   = ID_W'(src);
         b.data = base + DATA_W'(j);
         b.last = last_on_final && (j == first + n - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic load(input int src, input int n, input logic [DATA_W-1:0] base,
                       input int first, input bit last_on_final, input bit with_exp);
      for (int j = first; j < first + n; j++)
         fq[src].push_back({last_on_final && (j == first + n - 1), base + DATA_W'(j)});
      if (with_exp) push_exp(src, n, base, first, last_on_final);
      refresh();
   endtask

   task automatic apply_reset();
      rd_rst  = 1'b1;
      m_ready = 1'b1;
      clear_all();
      repeat (3) tick();
      rd_rst = 1'b0;
      tick();
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (exp_q.size() > 0 && k < 300) begin
         tick();
         k++;
      end
      n_checks++;
      if (exp_q.size() != 0)
         $display("FAIL %s_drain: %0d beats still outstanding, want 0", name, exp_q.size());
      else
         n_pass++;
   endtask

   task automatic chk_en(input string name, input logic [NUM_SRC-1:0] want);
      n_checks++;
      if (src_rd_en !== want)
         $display("FAIL %s: src_rd_en=%b want %b", name, src_rd_en, want);
      else
         n_pass++;
   endtask

   task automatic test_reset();
      rd_rst  = 1'b1;
      m_ready = 1'b1;
      clear_all();
      repeat (3) tick();
      n_checks++;
      if ({m_valid, m_data, m_last, m_src_id, err_overrun, src_rd_en} !== '0)
         $display("FAIL reset_values: valid=%b data=%h last=%b id=%0d err=%b en=%b",
                  m_valid, m_data, m_last, m_src_id, err_overrun, src_rd_en);
      else
         n_pass++;
      rd_rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         n_checks++;
         if (src_rd_en !== '0 || m_valid !== 1'b0)
            $display("FAIL reset_quiet: cycle %0d en=%b valid=%b want 0/0", c, src_rd_en, m_valid);
         else
            n_pass++;
      end
   endtask

   task automatic test_guard();
      rd_rst = 1'b1;
      clear_all();
      load(0, 2, 32'h0A00_0000, 0, 1'b1, 1'b1);
      repeat (3) tick();
      rd_rst = 1'b0;
      tick();
      chk_en("guard_first_cycle", 4'b0000);
      tick();
      chk_en("guard_grant", 4'b0001);
      drain("guard");
   endtask

   task automatic test_single_burst();
      apply_reset();
      load(1, 3, 32'hD100_0000, 0, 1'b1, 1'b1);
      chk_en("single_idle", 4'b0000);
      tick();
      chk_en("single_pop0", 4'b0010);
      n_checks++;
      if (m_valid !== 1'b0) $display("FAIL single_valid_early: m_valid=%b want 0", m_valid);
      else n_pass++;
      tick();
      chk_en("single_pop1", 4'b0010);
      n_checks++;
      if (m_valid !== 1'b1) $display("FAIL single_valid_t2: m_valid=%b want 1", m_valid);
      else n_pass++;
      tick();
      chk_en("single_pop2", 4'b0010);
      tick();
      chk_en("single_done", 4'b0000);
      drain("single");
   endtask

   task automatic test_round_robin();
      logic [NUM_SRC-1:0] seq_a [7];
      logic [NUM_SRC-1:0] seq_b [5];
      seq_a = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
      seq_b = '{4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
      apply_reset();
      load(0, 2, 32'hB000_0000, 0, 1'b1, 1'b1);
      load(2, 2, 32'hB200_0000, 0, 1'b1, 1'b1);
      for (int c = 0; c < 7; c++) begin
         if (c > 0) tick();
         chk_en($sformatf("rr_round1_c%0d", c), seq_a[c]);
      end
      load(3, 1, 32'hB300_0000, 0, 1'b1, 1'b1);
      load(0, 1, 32'hB000_0100, 0, 1'b1, 1'b1);
      for (int c = 0; c < 5; c++) begin
         if (c > 0) tick();
         chk_en($sformatf("rr_round2_c%0d", c), seq_b[c]);
      end
      drain("rr");
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] held;
      apply_reset();
      load(1, 4, 32'hC100_0000, 0, 1'b1, 1'b1);
      tick();
      tick();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      #1;
      chk_en("bp_stall_now", 4'b0000);
      held = m_data;
      n_checks++;
      if (held !== 32'hC100_0001) $display("FAIL bp_held_beat: m_data=%h want %h", held, 32'hC100_0001);
      else n_pass++;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk_en($sformatf("bp_stall_c%0d", c), 4'b0000);
         n_checks++;
         if (m_data !== held || m_valid !== 1'b1)
            $display("FAIL bp_stable_c%0d: data=%h valid=%b want %h/1", c, m_data, m_valid, held);
         else
            n_pass++;
      end
      m_ready = 1'b1;
      #1;
      chk_en("bp_resume", 4'b0010);
      drain("bp");
   endtask

   task automatic test_overrun();
      int pops = 0;
      apply_reset();
      n_checks++;
      if (err_overrun !== 1'b0) $display("FAIL ovr_initial: err_overrun=%b want 0", err_overrun);
      else n_pass++;
      load(3, 20, 32'hE300_0000, 0, 1'b0, 1'b0);
      push_exp(3, MAX_BEATS, 32'hE300_0000, 0, 1'b0);
      for (int c = 0; c < 60; c++) begin
         tick();
         if (src_rd_en == 4'b1000) pops++;
         else if (pops > 0) break;
      end
      n_checks++;
      if (pops != MAX_BEATS) $display("FAIL ovr_pops: got %0d pops want %0d", pops, MAX_BEATS);
      else n_pass++;
      n_checks++;
      if (err_overrun !== 1'b1) $display("FAIL ovr_flag: err_overrun=%b want 1", err_overrun);
      else n_pass++;
      push_exp(3, 20 - MAX_BEATS, 32'hE300_0000, MAX_BEATS, 1'b0);
      drain("ovr");
      repeat (5) tick();
      n_checks++;
      if (err_overrun !== 1'b1) $display("FAIL ovr_sticky: err_overrun=%b want 1", err_overrun);
      else n_pass++;
      apply_reset();
      n_checks++;
      if (err_overrun !== 1'b0) $display("FAIL ovr_cleared: err_overrun=%b want 0", err_overrun);
      else n_pass++;
   endtask

   task automatic test_empty_mid_burst();
      apply_reset();
      load(2, 2, 32'hF200_0000, 0, 1'b0, 1'b1);
      tick();
      chk_en("emb_pop0", 4'b0100);
      load(0, 2, 32'hF000_0000, 0, 1'b1, 1'b0);
      tick();
      chk_en("emb_pop1", 4'b0100);
      for (int c = 0; c < 6; c++) begin
         tick();
         chk_en($sformatf("emb_hold_c%0d", c), 4'b0000);
      end
      load(2, 1, 32'hF200_0000, 2, 1'b1, 1'b1);
      push_exp(0, 2, 32'hF000_0000, 0, 1'b1);
      #1;
      chk_en("emb_resume", 4'b0100);
      drain("emb");
   endtask

   initial begin
      rd_rst  = 1'b1;
      m_ready = 1'b1;
      clear_all();
      test_reset();
      test_guard();
      test_single_burst();
      test_round_robin();
      test_backpressure();
      test_overrun();
      test_empty_mid_burst();
      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
